// File: rtl/marin_bus_pkg.sv
// Shared Wishbone widths and the two-master arbiter state encoding for the Marin SoC bus.
// Constants only, so there is no latency and no backpressure.
package marin_bus_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 16;
    localparam int WB_SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    // Width of a counter that must be able to reach 'limit'; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Ack-wait counter: it counts cycles of an unacked strobe and flags when the count equals TIMEOUT.
// hit is combinational from the registered count. It does not stall anything; TIMEOUT=0 disables hit.
module wb_ack_timer
    import marin_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run,
    input  logic clear,
    output logic hit
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);
    localparam bit ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] cnt;

    // Saturate rather than wrap, so a missed hit can never alias back to a low count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = ENABLED && run && (cnt == LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin two-master Wishbone arbiter. Ownership lasts for the whole cyc, and a stalled ack is aborted with err.
// Grant takes one registered cycle from IDLE; within ownership the bus and ack paths are combinational; the non-owner waits.
module wb_arbiter2
    import marin_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic                m0_we_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,

    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic                m1_we_i,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,

    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic [WB_DAT_W-1:0] s_dat_i,
    input  logic                s_ack_i,

    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    arb_state_t state, state_nxt;
    logic       last, last_nxt;
    logic       own_stb;
    logic       tmr_run, tmr_clear, tmr_hit;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = 2'b00;
        timeout_o = 1'b0;

        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    state_nxt = ST_OWN0;
                end else if (m1_cyc_i) begin
                    state_nxt = ST_OWN1;
                end
            end

            ST_OWN0: begin
                grant_o  = 2'b01;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
                if (tmr_hit) begin
                    m0_err_o  = 1'b1;
                    timeout_o = 1'b1;
                    state_nxt = ST_ABORT;
                end else if (!m0_cyc_i) begin
                    state_nxt = m1_cyc_i ? ST_OWN1 : ST_IDLE;
                end
            end

            ST_OWN1: begin
                grant_o  = 2'b10;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
                if (tmr_hit) begin
                    m1_err_o  = 1'b1;
                    timeout_o = 1'b1;
                    state_nxt = ST_ABORT;
                end else if (!m1_cyc_i) begin
                    state_nxt = m0_cyc_i ? ST_OWN0 : ST_IDLE;
                end
            end

            // The bus stays dark and late acks are dropped until the aborted owner ends its cycle.
            ST_ABORT: begin
                grant_o = last ? 2'b10 : 2'b01;
                if (!(last ? m1_cyc_i : m0_cyc_i)) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        last_nxt = last;
        if (state_nxt == ST_OWN0) begin
            last_nxt = 1'b0;
        end else if (state_nxt == ST_OWN1) begin
            last_nxt = 1'b1;
        end
    end

    always_comb begin
        own_stb = 1'b0;
        tmr_run = 1'b0;
        if (state == ST_OWN0) begin
            own_stb = m0_stb_i;
            tmr_run = m0_cyc_i && m0_stb_i && !s_ack_i;
        end else if (state == ST_OWN1) begin
            own_stb = m1_stb_i;
            tmr_run = m1_cyc_i && m1_stb_i && !s_ack_i;
        end
    end

    assign tmr_clear = s_ack_i || !own_stb || (state_nxt != state);

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .run    (tmr_run),
        .clear  (tmr_clear),
        .hit    (tmr_hit)
    );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2 with TIMEOUT=8: directed scenarios first, then random two-master traffic
// checked against a simple ownership model kept here.
module tb_wb_arbiter2;
    import marin_bus_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr  [2];
    logic [15:0] wdat [2];
    logic [1:0]  sel  [2];
    logic        we   [2];
    logic        cyc  [2];
    logic        stb  [2];
    logic [15:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];
    logic [31:0] s_adr;
    logic [15:0] s_dat_o, s_dat_i;
    logic [1:0]  s_sel, grant;
    logic        s_we, s_cyc, s_stb, s_ack, tmo;

    int n_assert = 0;
    int n_fail   = 0;

    wb_arbiter2 #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_dat_o(rdat[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_dat_o(rdat[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
        .grant_o(grant), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] g, input logic c,
                           input logic a0, input logic a1);
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_scyc"}, 32'(s_cyc), 32'(c));
        chk({tag, "_ack0"}, 32'(ack[0]), 32'(a0));
        chk({tag, "_ack1"}, 32'(ack[1]), 32'(a1));
    endtask

    task automatic idle_m(input int m);
        cyc[m] = 1'b0;
        stb[m] = 1'b0;
        we[m]  = 1'b0;
    endtask

    task automatic req(input int m, input logic [31:0] a, input logic w);
        cyc[m]  = 1'b1;
        stb[m]  = 1'b1;
        adr[m]  = a;
        we[m]   = w;
        wdat[m] = 16'(a[15:0] ^ 16'h5A5A);
        sel[m]  = 2'b11;
    endtask

    int own, mlast, wt;
    int left [2];

    initial begin
        for (int m = 0; m < 2; m++) begin
            adr[m] = '0; wdat[m] = '0; sel[m] = '0; idle_m(m);
        end
        s_ack = 1'b1;
        s_dat_i = 16'h0;

        // Reset state, with a stray slave ack present
        #2;
        chk_bus("rst", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rst_sstb", 32'(s_stb), 32'h0);
        chk("rst_sadr", s_adr, 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        @(negedge clk); rst_n = 1'b1; s_ack = 1'b0;

        // Tie after reset: m0 first, then a direct handoff to m1
        @(negedge clk); req(0, 32'h0000_0100, 1'b0); req(1, 32'h0000_0200, 1'b1);
        #1 chk_bus("tie_req", 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); s_ack = 1'b1; s_dat_i = 16'hAAAA;
        #1 chk_bus("tie_own0", 2'b01, 1'b1, 1'b1, 1'b0);
        chk("tie_adr0", s_adr, 32'h0000_0100);
        @(negedge clk); s_ack = 1'b0; idle_m(0);
        #1 chk_bus("tie_rel0", 2'b01, 1'b0, 1'b0, 1'b0);
        @(negedge clk); s_ack = 1'b1;
        #1 chk_bus("tie_hand1", 2'b10, 1'b1, 1'b0, 1'b1);
        chk("tie_adr1", s_adr, 32'h0000_0200);
        chk("tie_we1", 32'(s_we), 32'h1);
        @(negedge clk); s_ack = 1'b0; idle_m(1);
        @(negedge clk);
        #1 chk_bus("tie_idle", 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); req(0, 32'h0000_0300, 1'b0); req(1, 32'h0000_0400, 1'b0);
        @(negedge clk);
        #1 chk_bus("tie2_own0", 2'b01, 1'b1, 1'b0, 1'b0);
        idle_m(0); idle_m(1);
        @(negedge clk); @(negedge clk);

        // Single-master read with two wait states
        @(negedge clk); req(0, 32'h1000_0000, 1'b0);
        #1 chk_bus("rd_req", 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 chk_bus("rd_w1", 2'b01, 1'b1, 1'b0, 1'b0);
        chk("rd_adr", s_adr, 32'h1000_0000);
        @(negedge clk);
        #1 chk_bus("rd_w2", 2'b01, 1'b1, 1'b0, 1'b0);
        @(negedge clk); s_ack = 1'b1; s_dat_i = 16'h1234;
        #1 chk_bus("rd_ack", 2'b01, 1'b1, 1'b1, 1'b0);
        chk("rd_dat", 32'(rdat[0]), 32'h1234);
        @(negedge clk); s_ack = 1'b0; idle_m(0);
        @(negedge clk);
        #1 chk_bus("rd_idle", 2'b00, 1'b0, 1'b0, 1'b0);

        // Locked burst on m1 while m0 waits
        @(negedge clk); req(1, 32'h2000_0000, 1'b1);
        @(negedge clk); req(0, 32'h2100_0000, 1'b0);
        #1 chk_bus("bu_own1", 2'b10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); s_ack = 1'b1; adr[1] = 32'h2000_0000 + 32'(2 * i);
            #1 chk_bus("bu_xfer", 2'b10, 1'b1, 1'b0, 1'b1);
            chk("bu_adr", s_adr, 32'h2000_0000 + 32'(2 * i));
        end
        @(negedge clk); s_ack = 1'b0; idle_m(1);
        #1 chk_bus("bu_rel1", 2'b10, 1'b0, 1'b0, 1'b0);
        @(negedge clk); s_ack = 1'b1;
        #1 chk_bus("bu_hand0", 2'b01, 1'b1, 1'b1, 1'b0);
        chk("bu_adr0", s_adr, 32'h2100_0000);
        @(negedge clk); s_ack = 1'b0; idle_m(0);
        @(negedge clk);

        // Timeout: the slave never acks
        @(negedge clk); req(0, 32'h3000_0000, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            #1 chk("to_wait_err", 32'(err[0]), 32'h0);
            chk("to_wait_tmo", 32'(tmo), 32'h0);
        end
        @(negedge clk);
        #1 chk("to_err0", 32'(err[0]), 32'h1);
        chk("to_tmo", 32'(tmo), 32'h1);
        chk("to_err1", 32'(err[1]), 32'h0);
        chk("to_grant", 32'(grant), 32'h1);
        @(negedge clk); s_ack = 1'b1;
        #1 chk_bus("to_abort", 2'b01, 1'b0, 1'b0, 1'b0);
        chk("to_abort_stb", 32'(s_stb), 32'h0);
        chk("to_abort_err", 32'(err[0]), 32'h0);
        @(negedge clk); s_ack = 1'b0; idle_m(0);
        #1 chk("to_hold", 32'(grant), 32'h1);
        @(negedge clk);
        #1 chk_bus("to_idle", 2'b00, 1'b0, 1'b0, 1'b0);

        // Ack arriving on the exact timeout cycle
        @(negedge clk); req(0, 32'h3100_0000, 1'b0);
        for (int k = 1; k <= TO; k++) @(negedge clk);
        @(negedge clk); s_ack = 1'b1;
        #1 chk_bus("race_ack", 2'b01, 1'b1, 1'b1, 1'b0);
        chk("race_err", 32'(err[0]), 32'h0);
        chk("race_tmo", 32'(tmo), 32'h0);
        @(negedge clk); s_ack = 1'b0;
        #1 chk_bus("race_after", 2'b01, 1'b1, 1'b0, 1'b0);
        chk("race_after_err", 32'(err[0]), 32'h0);
        @(negedge clk); idle_m(0);
        @(negedge clk);

        // Reset mid-transfer, then a tie must again go to m0
        @(negedge clk); req(0, 32'h4000_0000, 1'b1);
        @(negedge clk);
        #1 chk("mrst_own", 32'(grant), 32'h1);
        #2 rst_n = 1'b0; s_ack = 1'b1;
        #1 chk_bus("mrst", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("mrst_stb", 32'(s_stb), 32'h0);
        chk("mrst_adr", s_adr, 32'h0);
        chk("mrst_we", 32'(s_we), 32'h0);
        chk("mrst_tmo", 32'(tmo), 32'h0);
        @(negedge clk); idle_m(0); s_ack = 1'b0; rst_n = 1'b1;
        @(negedge clk); req(0, 32'h5000_0000, 1'b0); req(1, 32'h5100_0000, 1'b0);
        @(negedge clk);
        #1 chk_bus("mrst_tie", 2'b01, 1'b1, 1'b0, 1'b0);
        idle_m(0); idle_m(1);
        @(negedge clk); @(negedge clk);

        // Random traffic against the ownership model
        own = -1; mlast = 0; wt = 0; left[0] = 0; left[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            logic exp_stb;
            logic [1:0] g;
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!cyc[m]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req(m, $urandom, 1'($urandom));
                        sel[m] = 2'($urandom);
                        left[m] = $urandom_range(1, 4);
                    end
                end else if (left[m] == 0) begin
                    idle_m(m);
                end else begin
                    stb[m] = ($urandom_range(0, 5) != 0);
                end
            end
            exp_stb = (own >= 0) ? stb[own] : 1'b0;
            s_ack   = exp_stb && ((wt >= 3) || ($urandom_range(0, 1) == 1));
            s_dat_i = 16'($urandom);
            #1;
            g = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
            chk("rnd_grant", 32'(grant), 32'(g));
            chk("rnd_scyc", 32'(s_cyc), (own >= 0) ? 32'(cyc[own]) : 32'h0);
            chk("rnd_sstb", 32'(s_stb), 32'(exp_stb));
            chk("rnd_ack0", 32'(ack[0]), 32'(own == 0 && s_ack));
            chk("rnd_ack1", 32'(ack[1]), 32'(own == 1 && s_ack));
            chk("rnd_err", 32'({err[1], err[0], tmo}), 32'h0);
            chk("rnd_rdat", 32'({rdat[1], rdat[0]}), {s_dat_i, s_dat_i});
            if (own >= 0) begin
                chk("rnd_sadr", s_adr, adr[own]);
                chk("rnd_sdat", 32'(s_dat_o), 32'(wdat[own]));
                chk("rnd_ssel", 32'(s_sel), 32'(sel[own]));
                chk("rnd_swe", 32'(s_we), 32'(we[own]));
            end
            if (own >= 0 && stb[own] && s_ack) begin
                left[own]--;
                adr[own]  = $urandom;
                wdat[own] = 16'($urandom);
            end
            if (own >= 0 && cyc[own] && stb[own] && !s_ack) wt++;
            else wt = 0;
            if (own >= 0) begin
                if (!cyc[own]) begin
                    own = cyc[1 - own] ? 1 - own : -1;
                    if (own >= 0) mlast = own;
                    wt = 0;
                end
            end else begin
                if (cyc[0] && cyc[1]) own = 1 - mlast;
                else if (cyc[0]) own = 0;
                else if (cyc[1]) own = 1;
                if (own >= 0) mlast = own;
                wt = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone arbiter for the Marin SoC. It shares the single master port of `wb_intercon` between the MoxieLite core (master 0) and a second bus master (master 1, the GDB/debug engine or a future DMA). Arbitration is round-robin and happens at Wishbone-cycle granularity. A per-transfer ack timeout terminates a stalled cycle with an error to its owner, so a hung slave cannot lock out the other master.

## Interface
- `TIMEOUT`, default 255: cycles a strobed transfer may wait for `s_ack_i` before it is aborted; 0 disables the timeout.
- `clk_i` input 1: system clock (`clk_cpu`).
- `rst_ni` input 1: reset. One clock; reset is asynchronous and active-low.
- `m0_adr_i`, `m1_adr_i` input 32: master address.
- `m0_dat_i`, `m1_dat_i` input 16: master write data.
- `m0_sel_i`, `m1_sel_i` input 2: byte selects.
- `m0_we_i`, `m0_cyc_i`, `m0_stb_i` (and the `m1_` equivalents) input 1: Wishbone control.
- `m0_dat_o`, `m1_dat_o` output 16: read data; both carry `s_dat_i` unregistered.
- `m0_ack_o`, `m1_ack_o` output 1: ack, routed to the owner only.
- `m0_err_o`, `m1_err_o` output 1: one-cycle timeout error, routed to the owner only.
- `s_adr_o` output 32, `s_dat_o` output 16, `s_sel_o` output 2, `s_we_o`, `s_cyc_o`, `s_stb_o` output 1: toward `wb_intercon` master side.
- `s_dat_i` input 16, `s_ack_i` input 1: from `wb_intercon`.
- `grant_o` output 2: one-hot current owner; `00` when no master owns the bus.
- `timeout_o` output 1: one-cycle pulse on abort, intended for the PIC or LEDs.

## Operation
- FSM states are IDLE, OWN0, OWN1 and ABORT.
- `last` register holds the most recently granted master. It resets to 1, so master 0 wins the first tie.
- IDLE:
  - Only m0 `cyc_i` high → OWN0. Only m1 `cyc_i` high → OWN1.
  - Both high → the master other than `last` is granted.
  - Entering an OWN state updates `last`.
- OWNx:
  - `s_adr/dat/sel/we_o` are muxed from master x.
  - `s_cyc_o = mx_cyc_i`, `s_stb_o = mx_stb_i`.
  - `mx_ack_o = s_ack_i`; the non-owner sees ack=0 and err=0.
  - Ownership is held while `mx_cyc_i` stays high, which allows locked read-modify-write and bursts.
- Release: when `mx_cyc_i` falls in OWNx, the next state is OWNy if `my_cyc_i` is high (direct handoff), otherwise IDLE.
- Timeout counter:
  - Increments each OWN cycle with owner `cyc&stb` high and `s_ack_i` low.
  - Clears on `s_ack_i`, on `stb` low, and on any state change.
  - When the counter equals `TIMEOUT` (`TIMEOUT`≠0), assert `mx_err_o` and `timeout_o` for one cycle, then go to ABORT.
  - Counter width is `$clog2(TIMEOUT+1)` with a minimum of 1; it saturates and never wraps.
- ABORT:
  - `s_cyc_o`/`s_stb_o` are 0 and `grant_o` stays at the aborted owner.
  - A late `s_ack_i` is discarded.
  - Exit to IDLE once the aborted owner's `cyc_i` is low.
- Reset, including mid-transfer: state IDLE, `last`=1, counter 0. All `s_*` outputs, ack/err outputs, `grant_o` and `timeout_o` are 0 while `rst_ni` is low. The in-flight transfer is simply dropped.

## Timing
- Grant is registered. A request from IDLE is visible on `s_cyc_o` one cycle after `cyc_i` rises.
- Within OWN, the path to `s_*` is combinational (same cycle) and ack returns combinationally with zero added latency.
- Handoff OWNx→OWNy inserts no dead cycle: y's signals appear the cycle after x drops `cyc_i`.
- Simultaneous `s_ack_i` in the cycle the counter hits `TIMEOUT`: ack wins, no error, and the counter clears.
- The timeout error asserts on the cycle the counter equals `TIMEOUT`, i.e. `TIMEOUT+1` cycles after the strobe is first seen unacked in OWN.

## Structure
- A shared package `marin_bus_pkg` holds `WB_ADR_W`=32, `WB_DAT_W`=16, `WB_SEL_W`=2 and the FSM state enum.
- A natural sub-module is `wb_ack_timer`: counter, clear and saturate logic with a `hit` output, reusable by `wb_watchdog`.
- Everything else lives flat in `wb_arbiter2`.

## Test plan
- **Single-master read:** m0 single read at 0x10000000, slave acks after 2 cycles, `s_dat_i`=0x1234 → `m0_dat_o`=0x1234 with `m0_ack_o`, `grant_o`=01, and m1 sees no ack.
- **Tie after reset:** m0 and m1 assert `cyc` on the same cycle after reset → m0 granted first. After m0 releases, m1 is granted on the next cycle (no IDLE), and the next tie goes to m0.
- **Locked burst:** m1 holds `cyc` across 4 acked transfers while m0 requests → m0 waits until m1 drops `cyc`, then `grant_o`=01.
- **Timeout:** `TIMEOUT`=8, slave never acks → `m0_err_o` and `timeout_o` pulse 9 cycles after the strobe is first seen unacked in OWN0, `s_cyc_o` drops, and a late ack in ABORT is not forwarded.
- **Ack/timeout race:** ack arrives exactly on the timeout cycle → ack delivered, no err, state stays OWN0.
- **Reset mid-transfer:** `rst_ni` pulsed low mid-transfer → all outputs 0 immediately (asynchronous), FSM in IDLE, and m0 wins the next tie.
